rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin, packet-locked arbiter that shares one WIDTH-bit output channel among SIZE requesters using valid/ready handshakes. It chooses a winner, holds the grant until that requester's last beat is accepted, then advances fairness. The selected data passes through the existing mux_param instance into a one-entry registered output stage. It sits in front of shared single-port resources in the CU pipeline, for example a shared write-back or memory-request path.

Parameters:
BITS, 2, width of grant index / mux select; must satisfy 2^BITS >= SIZE
SIZE, 4, number of requesters (2..2^BITS; need not be a power of 2)
WIDTH, 32, data beat width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  SIZE  per-requester beat valid
req_last  input  SIZE  per-requester last beat of packet
req_data  input  SIZE*WIDTH  packed beats; requester i at bits [WIDTH*(i+1)-1 -: WIDTH]
req_ready  output  SIZE  per-requester beat accepted; one-hot or zero
out_valid  output  1  output beat valid
out_last  output  1  output beat is last of packet
out_data  output  WIDTH  output beat
out_src  output  BITS  index of requester that produced out_data
out_ready  input  1  downstream accepts output beat
busy  output  1  high in LOCK state

Behaviour:
- Reset (rst_n low, async): state=IDLE, grant=0, ptr=0, req_ready=0, out_valid=0, out_last=0, out_data=0, out_src=0, busy=0.
- States: IDLE, LOCK.
- IDLE:
  - req_ready all 0.
  - If any req_valid[i] (i<SIZE) is high, the winner is the first valid index scanning ptr, ptr+1, ... mod SIZE.
  - grant<=winner; state<=LOCK.
  - Otherwise stay in IDLE.
- LOCK:
  - can_load = !out_valid || out_ready.
  - req_ready[grant] = can_load; all other req_ready bits are 0.
  - Accept = req_valid[grant] && req_ready[grant].
  - On accept: out_data<=req_data slice grant (via mux_param, select=grant); out_last<=req_last[grant]; out_src<=grant; out_valid<=1.
  - If an accepted beat has req_last high: ptr<=(grant==SIZE-1)?0:grant+1; state<=IDLE.
- Output stage without a load: if out_valid && out_ready, then out_valid<=0.
  - Load and drain in the same cycle: the load wins and out_valid stays 1. This gives full throughput within a packet.
- Latency: req_valid rising in IDLE at cycle 0 -> grant registered at edge 1 -> req_ready at cycle 1 -> out_valid at cycle 2.
- Packets: exactly one IDLE bubble cycle between consecutive packets.
- Lock rule: no re-arbitration mid-packet. If the granted requester drops req_valid, the arbiter waits in LOCK indefinitely; there is no timeout. Other requesters are never granted until the last beat.
- Single-beat packet (req_last=1 on the first beat): LOCK lasts exactly 1 cycle if can_load is high.
- Requester protocol: once asserted, req_valid/req_data/req_last stay stable until accepted. The arbiter does not check this.
- Index wrap: the ptr wrap uses SIZE, not 2^BITS. Indices >= SIZE are never granted.
- Backpressure: out_ready low with out_valid high forces req_ready low. The held beat is unchanged until out_ready is seen high.
- Reset mid-packet: the in-flight beat and packet are discarded and ptr returns to 0. Upstream must restart the packet.

Decomposition:
- Shared package: state encoding constants (IDLE=1'b0, LOCK=1'b1).
- One natural sub-module, rr_pick: a combinational rotate-priority picker.
  - Inputs: req vector [SIZE], ptr [BITS].
  - Outputs: winner [BITS], any.
- The data path instantiates mux_param (BITS, SIZE, WIDTH) with select=grant.

Test Plan:
- Single requester: reset, req_valid=4'b0100, 3-beat packet A1..A3 with out_ready=1 -> grant=2; out_data=A1,A2,A3 on cycles 2,3,4; out_last only on A3; out_src=2; ptr=3 afterwards.
- Fairness: all four valid with single-beat packets, ptr=0 -> grant order 0,1,2,3,0, one bubble between each; req_ready one-hot throughout.
- Backpressure: out_ready=0 during beat 2 of a 3-beat packet -> out_data held, req_ready[grant]=0; release -> no beat lost or duplicated.
- Lock: requester 1 mid-packet drops req_valid for 5 cycles while requester 3 is valid -> grant stays 1, req_ready[3]=0, busy=1; resumes on beat 2.
- Wrap with SIZE=3, BITS=2: grant=2 last beat -> ptr=0; req_valid=3'b011 -> next grant=0.
- Async reset mid-packet: rst_n low between clock edges -> outputs zero immediately; after release, requester 2 valid -> grant=2 from ptr=0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin packet-locked arbiter.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } state_e;

    // Successor of idx in a ring of size entries; the ring is SIZE long, not 2^BITS.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned size);
        return (idx == size - 1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_param.sv
// Parameterised SIZE:1 mux over packed WIDTH-bit slices; out-of-range selects give zero.
module mux_param #(
    parameter int unsigned BITS  = 2,
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic [BITS-1:0]       sel_i,
    input  logic [SIZE*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]      data_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (sel_i == BITS'(i)) begin
                data_o = data_i[WIDTH*i +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request scanning ptr, ptr+1, ... modulo SIZE.
module rr_pick #(
    parameter int unsigned BITS = 2,
    parameter int unsigned SIZE = 4
) (
    input  logic [SIZE-1:0] req_i,
    input  logic [BITS-1:0] ptr_i,
    output logic [BITS-1:0] winner_o,
    output logic            any_o
);

    always_comb begin
        int unsigned idx;
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int unsigned k = 0; k < SIZE; k++) begin
            idx = (32'(ptr_i) + k) % SIZE;
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (!any_o && idx == i && req_i[i]) begin
                    any_o    = 1'b1;
                    winner_o = BITS'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that locks the grant for a whole packet and feeds a
// one-entry registered output stage.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned BITS  = 2,
    parameter int unsigned SIZE  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE-1:0]       req_valid,
    input  logic [SIZE-1:0]       req_last,
    input  logic [SIZE*WIDTH-1:0] req_data,
    output logic [SIZE-1:0]       req_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [WIDTH-1:0]      out_data,
    output logic [BITS-1:0]       out_src,
    input  logic                  out_ready,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [BITS-1:0]   grant_q, grant_d;
    logic [BITS-1:0]   ptr_q, ptr_d;
    logic [BITS-1:0]   out_src_q, out_src_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [BITS-1:0]   winner;
    logic              any_valid;
    logic [WIDTH-1:0]  mux_data;
    logic              can_load;
    logic              grant_valid;
    logic              grant_last;
    logic              accept;

    rr_pick #(
        .BITS (BITS),
        .SIZE (SIZE)
    ) u_pick (
        .req_i    (req_valid),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_valid)
    );

    mux_param #(
        .BITS  (BITS),
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i  (grant_q),
        .data_i (req_data),
        .data_o (mux_data)
    );

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (grant_q == BITS'(i)) begin
                grant_valid = req_valid[i];
                grant_last  = req_last[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        out_src_d  = out_src_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_valid_d = out_valid_q;
        req_ready  = '0;
        accept     = 1'b0;

        // Drain first so a same-cycle load below overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = StLock;
                end
            end
            StLock: begin
                for (int unsigned i = 0; i < SIZE; i++) begin
                    if (grant_q == BITS'(i)) begin
                        req_ready[i] = can_load;
                    end
                end
                accept = grant_valid && can_load;
                if (accept) begin
                    out_data_d  = mux_data;
                    out_last_d  = grant_last;
                    out_src_d   = grant_q;
                    out_valid_d = 1'b1;
                    if (grant_last) begin
                        ptr_d   = BITS'(wrap_inc(32'(grant_q), SIZE));
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            ptr_q       <= '0;
            out_src_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_src_q   <= out_src_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == StLock);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: per-requester beat queues drive the inputs,
// a monitor pops expected beats whenever an output beat is handed downstream.
module tb_rr_mux_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   req_valid, req_last, req_ready;
    logic [127:0] req_data;
    logic         out_valid, out_last, out_ready, busy;
    logic [31:0]  out_data;
    logic [1:0]   out_src;

    logic [2:0]   r3_valid, r3_last, r3_ready;
    logic [95:0]  r3_data;
    logic         o3_valid, o3_last, o3_ready, o3_busy;
    logic [31:0]  o3_data;
    logic [1:0]   o3_src;

    typedef struct packed {logic [31:0] data; logic last;} beat_t;
    typedef struct packed {logic [31:0] data; logic last; logic [1:0] src;} exp_t;

    beat_t      src_q[4][$];
    exp_t       exp_q[$];
    int         pop_cyc[$];
    int         cyc_cnt = 0;
    logic [3:0] hold = '0;
    int         checks = 0;
    int         errors = 0;

    rr_mux_arbiter #(.BITS(2), .SIZE(4), .WIDTH(32)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    rr_mux_arbiter #(.BITS(2), .SIZE(3), .WIDTH(32)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (r3_valid),
        .req_last  (r3_last),
        .req_data  (r3_data),
        .req_ready (r3_ready),
        .out_valid (o3_valid),
        .out_last  (o3_last),
        .out_data  (o3_data),
        .out_src   (o3_src),
        .out_ready (o3_ready),
        .busy      (o3_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.last = l;
        e.src  = s;
        exp_q.push_back(e);
    endtask

    // Queue an n-beat packet on requester r; optionally expect it next in output order.
    task automatic push_pkt(input int r, input logic [31:0] base, input int n, input bit expect_it);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + 32'(k);
            b.last = (k == n - 1);
            src_q[r].push_back(b);
            if (expect_it) push_exp(b.data, b.last, 2'(r));
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc(1);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        cyc(2);
    endtask

    // Requester driver: pop a beat once it was accepted, then present the next one.
    initial begin
        logic [3:0] acc;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready & {4{rst_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0 && !hold[i]) begin
                    req_valid[i]           = 1'b1;
                    req_last[i]            = src_q[i][0].last;
                    req_data[32*i +: 32]   = src_q[i][0].data;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: compare each beat handed downstream against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h src %0d expected none",
                                 out_data, out_src);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'({out_src, out_last, out_data}),
                              64'({e.src, e.last, e.data}));
                        pop_cyc.push_back(cyc_cnt);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        out_ready = 1'b1;
        o3_ready  = 1'b1;
        r3_valid  = '0;
        r3_last   = '0;
        r3_data   = '0;

        // Asynchronous reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_out", 64'({out_valid, out_last, out_src, busy, req_ready, out_data}), 64'd0);
        check("reset_out3", 64'({o3_valid, o3_last, o3_src, o3_busy, r3_ready, o3_data}), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        cyc(1);

        // Single requester, 3-beat packet
        push_pkt(2, 32'hA000_0001, 3, 1'b1);
        cyc(1);
        check("t1_c0_ready", 64'(req_ready), 64'd0);
        check("t1_c0_busy", 64'(busy), 64'd0);
        cyc(1);
        check("t1_c1_busy", 64'(busy), 64'd1);
        check("t1_c1_ready", 64'(req_ready), 64'(4'b0100));
        check("t1_c1_ovalid", 64'(out_valid), 64'd0);
        cyc(1);
        check("t1_c2_beat", 64'({out_valid, out_src, out_last, out_data}),
              64'({1'b1, 2'd2, 1'b0, 32'hA000_0001}));
        cyc(1);
        check("t1_c3_beat", 64'({out_valid, out_last, out_data}), 64'({1'b1, 1'b0, 32'hA000_0002}));
        cyc(1);
        check("t1_c4_beat", 64'({out_valid, out_last, out_data}), 64'({1'b1, 1'b1, 32'hA000_0003}));
        check("t1_c4_busy", 64'(busy), 64'd0);
        wait_drain("t1_drain", 20);

        // ptr must be 3: requesters 0 and 3 together -> 3 first
        push_pkt(0, 32'hB000_0000, 1, 1'b0);
        push_pkt(3, 32'hB000_0003, 1, 1'b0);
        push_exp(32'hB000_0003, 1'b1, 2'd3);
        push_exp(32'hB000_0000, 1'b1, 2'd0);
        wait_drain("ptr3_drain", 20);

        // Fairness from ptr=0 with single-beat packets on all requesters
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pop_cyc.delete();
        push_pkt(0, 32'hC000_0000, 1, 1'b0);
        push_pkt(0, 32'hC000_0010, 1, 1'b0);
        push_pkt(1, 32'hC000_0001, 1, 1'b0);
        push_pkt(2, 32'hC000_0002, 1, 1'b0);
        push_pkt(3, 32'hC000_0003, 1, 1'b0);
        push_exp(32'hC000_0000, 1'b1, 2'd0);
        push_exp(32'hC000_0001, 1'b1, 2'd1);
        push_exp(32'hC000_0002, 1'b1, 2'd2);
        push_exp(32'hC000_0003, 1'b1, 2'd3);
        push_exp(32'hC000_0010, 1'b1, 2'd0);
        wait_drain("fair_drain", 40);
        check("fair_count", 64'(pop_cyc.size()), 64'd5);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check("fair_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd2);
        end

        // Backpressure on beat 2 of a 3-beat packet (ptr=1)
        push_pkt(1, 32'hD000_0001, 3, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc(1);
            if (out_valid && out_data == 32'hD000_0002) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_found", 64'(found), 64'd1);
        out_ready = 1'b0;
        #1;
        check("bp_ready_low", 64'(req_ready), 64'd0);
        for (int n = 0; n < 3; n++) begin
            cyc(1);
            check("bp_hold", 64'({out_valid, out_data, req_ready}),
                  64'({1'b1, 32'hD000_0002, 4'b0000}));
        end
        out_ready = 1'b1;
        wait_drain("bp_drain", 20);

        // Lock: requester 1 stalls mid-packet while requester 3 waits (ptr=2)
        push_pkt(1, 32'hE000_0001, 3, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc(1);
            if (req_ready[1]) begin
                found = 1'b1;
                break;
            end
        end
        check("lock_found", 64'(found), 64'd1);
        hold[1] = 1'b1;
        push_pkt(3, 32'hE000_0003, 1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            cyc(1);
            check("lock_hold", 64'({busy, req_ready, req_valid[1]}), 64'({1'b1, 4'b0010, 1'b0}));
        end
        hold[1] = 1'b0;
        wait_drain("lock_drain", 30);

        // Wrap on the SIZE=3 instance: grant 2 then ptr returns to 0
        r3_valid = 3'b100;
        r3_last  = 3'b100;
        r3_data[95:64] = 32'hF000_0002;
        cyc(1);
        check("wrap_ready2", 64'(r3_ready), 64'(3'b100));
        cyc(1);
        r3_valid = 3'b000;
        check("wrap_beat2", 64'({o3_valid, o3_src, o3_last, o3_data, o3_busy}),
              64'({1'b1, 2'd2, 1'b1, 32'hF000_0002, 1'b0}));
        r3_valid = 3'b011;
        r3_last  = 3'b011;
        r3_data[31:0]  = 32'hF000_0000;
        r3_data[63:32] = 32'hF000_0001;
        cyc(1);
        check("wrap_ready0", 64'(r3_ready), 64'(3'b001));
        cyc(1);
        r3_valid = 3'b010;
        check("wrap_beat0", 64'({o3_src, o3_data}), 64'({2'd0, 32'hF000_0000}));
        cyc(2);
        r3_valid = 3'b000;
        check("wrap_beat1", 64'({o3_src, o3_data}), 64'({2'd1, 32'hF000_0001}));

        // Asynchronous reset mid-packet
        push_pkt(0, 32'h1000_0001, 3, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc(1);
            if (out_valid && out_data == 32'h1000_0001) begin
                found = 1'b1;
                break;
            end
        end
        check("arst_found", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        #1;
        check("arst_out", 64'({out_valid, out_last, out_src, busy, req_ready, out_data}), 64'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        push_pkt(2, 32'h2000_0002, 1, 1'b1);
        cyc(2);
        check("arst_grant2", 64'({busy, req_ready}), 64'({1'b1, 4'b0100}));
        wait_drain("arst_drain", 20);

        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
